// File: rtl/sid_filter_seq.sv
// Filter sequencer: shadows CPU writes to $15-$18, commits them at
// sample ticks, starts the filter and captures its result.
module sid_filter_seq #(
  parameter int unsigned DIV = 32,
  parameter int unsigned LAT = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_1m,
  input  logic        bus_we,
  input  logic [4:0]  bus_addr,
  input  logic [7:0]  bus_din,
  input  logic        overrun_clr,
  output logic [7:0]  fc_lo,
  output logic [7:0]  fc_hi,
  output logic [7:0]  res_filt,
  output logic [7:0]  mode_vol,
  output logic        filt_valid,
  input  logic [17:0] filt_sound,
  output logic [17:0] sample_out,
  output logic        sample_strobe,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  // Index 0..3 = fc_lo, fc_hi, res_filt, mode_vol
  logic [3:0][7:0] shd_q, shd_d;
  logic [3:0][7:0] act_q, act_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [4:0]      lat_q, lat_d;
  state_e          state_q, state_d;
  logic [17:0]     smp_q, smp_d;
  logic            ovr_q, ovr_d;
  logic            wrap;
  logic            tick;
  logic            fv;
  logic            stb;

  always_comb begin
    wrap  = cnt_q == 8'(DIV - 1);
    tick  = ~rst & ce_1m & wrap;
    cnt_d = cnt_q;
    if (ce_1m) begin
      cnt_d = wrap ? 8'd0 : cnt_q + 8'd1;
    end
  end

  always_comb begin
    shd_d = shd_q;
    if (bus_we) begin
      case (bus_addr)
        5'h15:   shd_d[0] = bus_din;
        5'h16:   shd_d[1] = bus_din;
        5'h17:   shd_d[2] = bus_din;
        5'h18:   shd_d[3] = bus_din;
        default: ;
      endcase
    end
  end

  // A tick that lands on the capture cycle still counts as busy.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    act_d   = act_q;
    smp_d   = smp_q;
    fv      = 1'b0;
    stb     = 1'b0;
    ovr_d   = overrun_clr ? 1'b0 : ovr_q;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          act_d   = shd_q;
          fv      = 1'b1;
          lat_d   = 5'(LAT - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        if (tick) begin
          ovr_d = 1'b1;
        end
        if (lat_q == 5'd0) begin
          smp_d   = filt_sound;
          stb     = ~rst;
          state_d = IDLE;
        end else begin
          lat_d = lat_q - 5'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shd_q   <= '0;
      act_q   <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
      state_q <= IDLE;
      smp_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      shd_q   <= shd_d;
      act_q   <= act_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      state_q <= state_d;
      smp_q   <= smp_d;
      ovr_q   <= ovr_d;
    end
  end

  assign fc_lo         = act_q[0];
  assign fc_hi         = act_q[1];
  assign res_filt      = act_q[2];
  assign mode_vol      = act_q[3];
  assign filt_valid    = fv;
  assign sample_out    = smp_q;
  assign sample_strobe = stb;
  assign busy          = state_q == RUN;
  assign overrun       = ovr_q;

endmodule

// File: tb/tb_sid_filter_seq.sv
// Bench for sid_filter_seq: default instance plus a DIV=16/LAT=31
// instance for the overrun scenario.
module tb_sid_filter_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce_a = 1'b0;
  logic        ce_b = 1'b0;
  logic        bus_we = 1'b0;
  logic [4:0]  bus_addr = '0;
  logic [7:0]  bus_din = '0;
  logic        ovr_clr = 1'b0;
  logic [17:0] fs_a = '0;
  logic [17:0] fs_b = '0;

  logic [7:0]  a_lo, a_hi, a_res, a_mode;
  logic        a_fv, a_stb, a_busy, a_ovr;
  logic [17:0] a_smp;
  logic [7:0]  b_lo, b_hi, b_res, b_mode;
  logic        b_fv, b_stb, b_busy, b_ovr;
  logic [17:0] b_smp;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ce_since = 0;
  int exp_q_a[$];
  int exp_q_b[$];
  int fv_cyc[$];
  int fv_ce[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sid_filter_seq u_a (
    .clk(clk), .rst(rst), .ce_1m(ce_a),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_din(bus_din),
    .overrun_clr(ovr_clr),
    .fc_lo(a_lo), .fc_hi(a_hi), .res_filt(a_res), .mode_vol(a_mode),
    .filt_valid(a_fv), .filt_sound(fs_a),
    .sample_out(a_smp), .sample_strobe(a_stb),
    .busy(a_busy), .overrun(a_ovr)
  );

  sid_filter_seq #(.DIV(16), .LAT(31)) u_b (
    .clk(clk), .rst(rst), .ce_1m(ce_b),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_din(bus_din),
    .overrun_clr(ovr_clr),
    .fc_lo(b_lo), .fc_hi(b_hi), .res_filt(b_res), .mode_vol(b_mode),
    .filt_valid(b_fv), .filt_sound(fs_b),
    .sample_out(b_smp), .sample_strobe(b_stb),
    .busy(b_busy), .overrun(b_ovr)
  );

  initial forever begin
    @(posedge clk);
    #1;
    fs_a = 18'($urandom);
    fs_b = 18'($urandom);
  end

  // Scoreboard A: strobe due LAT cycles after filt_valid
  initial begin
    logic        pend;
    logic [17:0] es;
    int          e;
    pend = 1'b0;
    es = '0;
    forever begin
      @(negedge clk);
      if (pend) begin
        total++;
        if (a_smp !== es) begin
          bad++;
          $display("FAIL a_sample got=%h exp=%h", a_smp, es);
        end
        pend = 1'b0;
      end
      if (ce_a) ce_since++;
      if (a_fv) begin
        exp_q_a.push_back(cyc + 12);
        fv_cyc.push_back(cyc);
        fv_ce.push_back(ce_since);
      end
      if (a_stb) begin
        total++;
        if (exp_q_a.size() == 0) begin
          bad++;
          $display("FAIL a_strobe unexpected at cyc=%0d", cyc);
        end else begin
          e = exp_q_a.pop_front();
          if (cyc !== e) begin
            bad++;
            $display("FAIL a_strobe_cyc got=%0d exp=%0d", cyc, e);
          end
        end
        es = fs_a;
        pend = 1'b1;
      end
    end
  end

  // Scoreboard B
  initial begin
    logic        pend;
    logic [17:0] es;
    int          e;
    pend = 1'b0;
    es = '0;
    forever begin
      @(negedge clk);
      if (pend) begin
        total++;
        if (b_smp !== es) begin
          bad++;
          $display("FAIL b_sample got=%h exp=%h", b_smp, es);
        end
        pend = 1'b0;
      end
      if (b_fv) exp_q_b.push_back(cyc + 31);
      if (b_stb) begin
        total++;
        if (exp_q_b.size() == 0) begin
          bad++;
          $display("FAIL b_strobe unexpected at cyc=%0d", cyc);
        end else begin
          e = exp_q_b.pop_front();
          if (cyc !== e) begin
            bad++;
            $display("FAIL b_strobe_cyc got=%0d exp=%0d", cyc, e);
          end
        end
        es = fs_b;
        pend = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    ce_a = 1'b0;
    ce_b = 1'b0;
    bus_we = 1'b0;
    ovr_clr = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    bus_we = 1'b1;
    bus_addr = a;
    bus_din = d;
  endtask

  task automatic pulse_a(input int n, input int gap);
    repeat (n) begin
      step();
      ce_a = 1'b1;
      repeat (gap - 1) step();
    end
  endtask

  // Leaves A one ce_1m pulse short of its next tick.
  task automatic to_pre_tick();
    int need;
    step();
    @(negedge clk);
    need = (31 - (ce_since % 32) + 32) % 32;
    pulse_a(need, 1);
  endtask

  task automatic test_reset();
    repeat (3) step();
    @(negedge clk);
    total++;
    if ({a_lo, a_hi, a_res, a_mode, a_fv, a_smp, a_stb, a_busy, a_ovr} !== '0) begin
      bad++;
      $display("FAIL reset_a got=%h exp=0",
        {a_lo, a_hi, a_res, a_mode, a_fv, a_smp, a_stb, a_busy, a_ovr});
    end
    total++;
    if ({b_lo, b_hi, b_res, b_mode, b_fv, b_smp, b_stb, b_busy, b_ovr} !== '0) begin
      bad++;
      $display("FAIL reset_b got=%h exp=0",
        {b_lo, b_hi, b_res, b_mode, b_fv, b_smp, b_stb, b_busy, b_ovr});
    end
    step();
    rst = 1'b0;
    ce_since = 0;
  endtask

  task automatic test_period();
    fv_cyc.delete();
    fv_ce.delete();
    pulse_a(64, 32);
    repeat (20) step();
    @(negedge clk);
    total++;
    if (fv_cyc.size() !== 2) begin
      bad++;
      $display("FAIL period_count got=%0d exp=2", fv_cyc.size());
    end else begin
      total++;
      if (fv_ce[0] !== 32) begin
        bad++;
        $display("FAIL first_fv_ce got=%0d exp=32", fv_ce[0]);
      end
      total++;
      if (fv_ce[1] !== 64) begin
        bad++;
        $display("FAIL second_fv_ce got=%0d exp=64", fv_ce[1]);
      end
      total++;
      if (fv_cyc[1] - fv_cyc[0] !== 1024) begin
        bad++;
        $display("FAIL fv_period got=%0d exp=1024", fv_cyc[1] - fv_cyc[0]);
      end
    end
    total++;
    if (exp_q_a.size() !== 0) begin
      bad++;
      $display("FAIL period_strobes_pending got=%0d exp=0", exp_q_a.size());
    end
  endtask

  task automatic test_commit_race();
    to_pre_tick();
    step();
    wr(5'h16, 8'hA5);
    step();
    ce_a = 1'b1;
    wr(5'h15, 8'h07);
    @(negedge clk);
    total++;
    if (a_fv !== 1'b1) begin
      bad++;
      $display("FAIL race_fv got=%b exp=1", a_fv);
    end
    step();
    @(negedge clk);
    total++;
    if ({a_hi, a_lo} !== 16'hA500) begin
      bad++;
      $display("FAIL race_commit got=%h exp=a500", {a_hi, a_lo});
    end
  endtask

  task automatic test_run_write();
    step();
    wr(5'h18, 8'h0F);
    @(negedge clk);
    total++;
    if (a_busy !== 1'b1) begin
      bad++;
      $display("FAIL run_busy got=%b exp=1", a_busy);
    end
    repeat (15) step();
    @(negedge clk);
    total++;
    if ({a_busy, a_mode} !== 9'h000) begin
      bad++;
      $display("FAIL run_frozen got=%h exp=000", {a_busy, a_mode});
    end
    to_pre_tick();
    step();
    ce_a = 1'b1;
    @(negedge clk);
    total++;
    if (a_fv !== 1'b1) begin
      bad++;
      $display("FAIL run_next_fv got=%b exp=1", a_fv);
    end
    step();
    @(negedge clk);
    total++;
    if ({a_lo, a_hi, a_mode} !== 24'h07A50F) begin
      bad++;
      $display("FAIL run_commit got=%h exp=07a50f", {a_lo, a_hi, a_mode});
    end
  endtask

  task automatic test_bad_addr();
    step();
    wr(5'h04, 8'hFF);
    step();
    wr(5'h19, 8'h12);
    step();
    wr(5'h14, 8'h33);
    step();
    wr(5'h17, 8'h5C);
    @(negedge clk);
    total++;
    if ({a_lo, a_hi, a_res, a_mode} !== 32'h07A5000F) begin
      bad++;
      $display("FAIL addr_no_change got=%h exp=07a5000f",
        {a_lo, a_hi, a_res, a_mode});
    end
    to_pre_tick();
    step();
    ce_a = 1'b1;
    step();
    @(negedge clk);
    total++;
    if ({a_lo, a_hi, a_res, a_mode} !== 32'h07A55C0F) begin
      bad++;
      $display("FAIL addr_commit got=%h exp=07a55c0f",
        {a_lo, a_hi, a_res, a_mode});
    end
  endtask

  task automatic test_rst_mid_run();
    to_pre_tick();
    step();
    ce_a = 1'b1;
    @(negedge clk);
    total++;
    if (a_fv !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre_fv got=%b exp=1", a_fv);
    end
    repeat (4) step();
    step();
    rst = 1'b1;
    exp_q_a.delete();
    step();
    rst = 1'b0;
    ce_since = 0;
    fv_cyc.delete();
    fv_ce.delete();
    @(negedge clk);
    total++;
    if ({a_lo, a_hi, a_res, a_mode, a_fv, a_smp, a_stb, a_busy, a_ovr} !== '0) begin
      bad++;
      $display("FAIL rst_mid_run got=%h exp=0",
        {a_lo, a_hi, a_res, a_mode, a_fv, a_smp, a_stb, a_busy, a_ovr});
    end
    repeat (40) step();
    pulse_a(32, 4);
    repeat (20) step();
    @(negedge clk);
    total++;
    if (fv_ce.size() !== 1) begin
      bad++;
      $display("FAIL rst_refv_count got=%0d exp=1", fv_ce.size());
    end else begin
      total++;
      if (fv_ce[0] !== 32) begin
        bad++;
        $display("FAIL rst_refv_ce got=%0d exp=32", fv_ce[0]);
      end
    end
  endtask

  task automatic test_overrun();
    logic ef;
    @(negedge clk);
    total++;
    if (b_ovr !== 1'b0) begin
      bad++;
      $display("FAIL ovr_init got=%b exp=0", b_ovr);
    end
    for (int i = 1; i <= 70; i++) begin
      step();
      ce_b = 1'b1;
      if (i == 40 || i == 64) ovr_clr = 1'b1;
      @(negedge clk);
      if (i % 16 == 0) begin
        ef = ((i / 16) % 2) == 1;
        total++;
        if (b_fv !== ef) begin
          bad++;
          $display("FAIL ovr_fv i=%0d got=%b exp=%b", i, b_fv, ef);
        end
      end
      if (i == 32) begin
        total++;
        if (b_busy !== 1'b1) begin
          bad++;
          $display("FAIL ovr_busy got=%b exp=1", b_busy);
        end
      end
      if (i == 33 || i == 65) begin
        total++;
        if (b_ovr !== 1'b1) begin
          bad++;
          $display("FAIL ovr_set i=%0d got=%b exp=1", i, b_ovr);
        end
      end
      if (i == 41 || i == 63) begin
        total++;
        if (b_ovr !== 1'b0) begin
          bad++;
          $display("FAIL ovr_clr i=%0d got=%b exp=0", i, b_ovr);
        end
      end
    end
    repeat (20) step();
    @(negedge clk);
    total++;
    if (exp_q_b.size() !== 0) begin
      bad++;
      $display("FAIL ovr_strobes_pending got=%0d exp=0", exp_q_b.size());
    end
  endtask

  initial begin
    test_reset();
    test_period();
    test_commit_race();
    test_run_write();
    test_bad_addr();
    test_rst_mid_run();
    test_overrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end

endmodule
